// File: rtl/log_drain_ctrl_if.sv
// Bundle between the log drain controller, the logger/RAM pair and the host consumer.
// master = controller side, slave = logger/RAM/host side.
interface log_drain_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 37
);
  logic              log_we;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              drain_start;
  logic              clr_req;
  logic              clr_ram;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              overflow;
  logic [ADDR_W:0]   count;

  modport master (
    input  log_we, rd_data, drain_start, clr_req, out_ready,
    output rd_en, rd_addr, clr_ram, out_valid, out_data, busy, overflow, count
  );

  modport slave (
    output log_we, rd_data, drain_start, clr_req, out_ready,
    input  rd_en, rd_addr, clr_ram, out_valid, out_data, busy, overflow, count
  );
endinterface

// File: rtl/log_drain_ctrl.sv
// Drains unread log RAM entries to a valid/ready consumer; drain_start -> out_valid in 3 cycles, 1 entry / 3 cycles.
// Backpressure: PRESENT holds out_valid/out_data until out_ready; clr_req pre-empts everything.
module log_drain_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 37
) (
  input  logic             clk,
  input  logic             reset_n,
  log_drain_ctrl_if.master bus
);
  localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, PRESENT, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              drop_flag_q, drop_flag_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              clr_ram_q;
  logic              full;
  logic              pop;
  logic              pop_eff;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_flag_d = drop_flag_q;
    out_data_d  = out_data_q;
    full        = (count_q == CNT_FULL);
    pop         = (state_q == PRESENT) && bus.out_ready;
    // A pop after a drop retires a slot the overwrite already reclaimed.
    pop_eff     = pop && !drop_flag_q;

    if (bus.clr_req) begin
      state_d = CLEAR;
    end else if (state_q == CLEAR) begin
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      drop_flag_d = 1'b0;
      state_d     = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.drain_start && (count_q != '0)) state_d = READ;
        READ: begin
          drop_flag_d = 1'b0;
          state_d     = WAIT;
        end
        WAIT: begin
          out_data_d = bus.rd_data;
          state_d    = PRESENT;
        end
        PRESENT: state_d = PRESENT;
        default: state_d = IDLE;
      endcase

      if (bus.log_we && pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else if (bus.log_we) begin
        if (!full) begin
          count_d = count_q + CNT_ONE;
        end else begin
          // Logger overwrote the oldest unread slot.
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          overflow_d = 1'b1;
          if ((state_q == WAIT) || (state_q == PRESENT)) drop_flag_d = 1'b1;
        end
      end else if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end

      if (pop) state_d = (count_d != '0) ? READ : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_flag_q <= 1'b0;
      out_data_q  <= '0;
      clr_ram_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_flag_q <= drop_flag_d;
      out_data_q  <= out_data_d;
      clr_ram_q   <= (state_d == CLEAR);
    end
  end

  assign bus.rd_en     = (state_q == READ);
  assign bus.rd_addr   = (state_q == READ) ? rd_ptr_q : '0;
  assign bus.clr_ram   = clr_ram_q;
  assign bus.out_valid = (state_q == PRESENT);
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overflow  = overflow_q;
  assign bus.count     = count_q;
endmodule

// File: doc/log_drain_ctrl.md
# log_drain_ctrl

Read-out controller for the security-event log RAM. It tracks how many unread entries the logger has written and sequences synchronous reads from the RAM. It presents each 37-bit entry to the host-side consumer over a valid/ready handshake, and owns the clr_ram pulse that rewinds the logger. It sits between the logger/RAM pair and the debug/host read port.

## Interface
- ADDR_W, 16, log RAM address width; depth DEPTH = 2^ADDR_W.
- DATA_W, 37, log entry width ({type[2:0], pc, addr, en, wr}).
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- log_we  in  1  logger write strobe; one entry written this cycle.
- rd_en  out  1  RAM read enable; one-cycle pulse.
- rd_addr  out  ADDR_W  RAM read address, meaningful when rd_en=1.
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en.
- drain_start  in  1  pulse: drain all unread entries.
- clr_req  in  1  pulse: discard log and rewind logger.
- clr_ram  out  1  registered one-cycle pulse to the logger.
- out_valid  out  1  out_data holds an entry.
- out_data  out  DATA_W  entry being presented.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: at least one entry was overwritten unread.
- count  out  ADDR_W+1  unread entries, 0..DEPTH.

## Operation
- State machine states are IDLE, READ, WAIT, PRESENT and CLEAR.
- IDLE: on drain_start with count>0, go to READ. drain_start with count=0 is ignored.
- READ: drive rd_en=1 and rd_addr=rd_ptr, clear drop_flag, go to WAIT.
- WAIT: capture rd_data into out_data at the closing edge, go to PRESENT.
- PRESENT: hold out_valid=1 and out_data stable until out_ready. On acceptance, apply the pop rule below. Then go to READ if the post-update count>0, otherwise go to IDLE. Entries logged during a drain are also drained.
- CLEAR (entered from any state on clr_req; clr_req has priority over all other inputs):
  - clr_ram=1 for this single cycle.
  - out_valid=0; any in-flight entry is discarded.
  - Next edge: rd_ptr=0, count=0, overflow=0, drop_flag=0; go to IDLE.
  - log_we in the CLEAR cycle is ignored.
- Write rule (log_we=1, state != CLEAR):
  - If count<DEPTH, count+1.
  - If count=DEPTH (full, oldest slot overwritten): count unchanged, rd_ptr+1, overflow=1, and drop_flag=1 if state is WAIT or PRESENT.
- Pop rule (PRESENT acceptance):
  - If drop_flag=0: rd_ptr+1 and count-1.
  - If drop_flag=1: the slot was already consumed by the drop, so rd_ptr and count are unchanged by the pop.
- Simultaneous write and pop:
  - count<DEPTH: net count unchanged; rd_ptr advances per the pop rule.
  - count=DEPTH: the pop frees the slot, so no drop occurs; count unchanged, rd_ptr+1, overflow unchanged.
- Arithmetic rules:
  - rd_ptr is ADDR_W bits and wraps DEPTH-1 → 0.
  - count never exceeds DEPTH and never underflows.
  - The pointer rewinds to 0 exactly when clr_ram fires, mirroring the logger's wr_addr rewind.

## Timing
- Reset values:
  - state IDLE, rd_ptr 0, count 0, overflow 0, drop_flag 0.
  - rd_en 0, rd_addr 0, clr_ram 0, out_valid 0, out_data 0, busy 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from out_ready or log_we to any output.
- Latency: drain_start sampled at edge E0 → rd_en high in cycle E0..E1 → out_valid high from E2.
- Throughput: one entry per 3 cycles when out_ready is held high.
- count reflects a write one cycle after the log_we edge.
- clr_req sampled at edge E → clr_ram high for exactly one cycle (E..E+1) → busy=0 and count=0 from E+1.
- reset_n asserted mid-drain: all state clears immediately (async); out_valid drops without a handshake.

## Test plan
- Reset, 3 log_we pulses, drain_start with out_ready=1:
  - rd_addr 0, 1, 2 observed.
  - 3 out_valid handshakes spaced 3 cycles apart, each out_data equal to the RAM contents.
  - count returns 0 and busy falls.
- drain_start with count=0:
  - No rd_en, busy stays 0.
- Backpressure: hold out_ready=0 for 10 cycles in PRESENT:
  - out_valid and out_data stay constant, no second rd_en.
  - Release → one handshake.
- Fill with DEPTH writes (ADDR_W=4, DEPTH=16), then 2 more:
  - count=16, overflow=1, rd_ptr=2.
  - Drain yields entries from addresses 2..15, 0, 1.
- Overflow while the entry from slot 5 is in PRESENT (count=16):
  - drop_flag set.
  - On acceptance, count stays 16 and rd_ptr stays 6.
- clr_req during WAIT:
  - clr_ram pulses for one cycle, out_valid never rises.
  - count=0, overflow=0, and the next drain reads from address 0.
